// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB3 command bridge.
package apb_master_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        timeout;
   } apb_rsp_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;
   localparam int DEFAULT_TO_WIDTH       = 8;

endpackage

// File: rtl/apb_master_cmd_bridge.sv
// APB3 initiator: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one registered response per command.
module apb_master_cmd_bridge
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TO_WIDTH       = DEFAULT_TO_WIDTH
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]               cmd_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic                      busy,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam logic                      TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [TO_WIDTH-1:0]       TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK = ~APB_ADDR_WIDTH'(3);

   apb_state_t                state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      busy_q, busy_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      rsp_valid_q, rsp_valid_d;
   apb_rsp_t                  rsp_q, rsp_d;
   logic [TO_WIDTH-1:0]       to_cnt_q, to_cnt_d;

   always_comb begin
      state_d  = state_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rsp_d    = rsp_q;
      to_cnt_d = to_cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d  = SETUP;
               paddr_d  = cmd_addr & ADDR_MASK;
               pwdata_d = cmd_wdata;
               pwrite_d = cmd_write;
               to_cnt_d = '0;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            // PREADY is checked first so a completion in the last allowed cycle wins
            if (PREADY) begin
               rsp_d.rdata   = pwrite_q ? 32'h0 : PRDATA;
               rsp_d.err     = PSLVERR;
               rsp_d.timeout = 1'b0;
               state_d       = RESP;
            end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
               rsp_d.rdata   = 32'h0;
               rsp_d.err     = 1'b1;
               rsp_d.timeout = 1'b1;
               state_d       = RESP;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      psel_d      = (state_d == SETUP) || (state_d == ACCESS);
      penable_d   = (state_d == ACCESS);
      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign busy        = busy_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_cmd_bridge.sv
// Directed plus randomized bench for apb_master_cmd_bridge; the bench plays the
// requester, the APB responder and the response consumer.
module tb_apb_master_cmd_bridge;

   localparam int TO = 8;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        busy;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   apb_master_cmd_bridge #(
      .APB_ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(TO),
      .TO_WIDTH(4)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full command/response exchange; expectations come from the transfer rules:
   // the responder answers after 'waits' wait states unless the timeout fires first.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] rd_in, input bit slverr,
                       input int hold);
      int          guard;
      int          acc;
      int          exp_acc;
      bit          exp_to;
      bit          exp_err;
      logic [31:0] exp_paddr;
      logic [31:0] exp_rdata;

      exp_paddr = addr & 32'hFFFF_FFFC;
      exp_to    = (waits >= TO);
      exp_acc   = exp_to ? TO : waits + 1;
      exp_rdata = (exp_to || wr) ? 32'h0 : rd_in;
      exp_err   = exp_to ? 1'b1 : slverr;

      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge HCLK);
         guard++;
      end
      chk("cmd_ready_wait", 64'(guard < 20), 64'(1));
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      @(negedge HCLK);
      // scramble the command bus so only registered values can pass
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;

      chk("setup_psel", 64'(PSEL), 64'(1));
      chk("setup_penable", 64'(PENABLE), 64'(0));
      chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("setup_busy", 64'(busy), 64'(1));
      chk("setup_paddr", 64'(PADDR), 64'(exp_paddr));
      chk("setup_pwrite", 64'(PWRITE), 64'(wr));
      chk("setup_pwdata", 64'(PWDATA), 64'(wdata));
      @(negedge HCLK);

      acc = 0;
      while (PSEL && PENABLE && acc < 40) begin
         acc++;
         chk("access_paddr", 64'(PADDR), 64'(exp_paddr));
         chk("access_pwdata", 64'(PWDATA), 64'(wdata));
         PREADY  = (acc == waits + 1);
         PRDATA  = PREADY ? rd_in : $urandom;
         PSLVERR = PREADY ? slverr : 1'($urandom);
         @(negedge HCLK);
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;

      chk("access_cycles", 64'(acc), 64'(exp_acc));
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_psel", 64'(PSEL), 64'(0));
      chk("rsp_penable", 64'(PENABLE), 64'(0));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(exp_err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
      chk("rsp_paddr_hold", 64'(PADDR), 64'(exp_paddr));

      for (int i = 0; i < hold; i++) begin
         @(negedge HCLK);
         chk("stall_valid", 64'(rsp_valid), 64'(1));
         chk("stall_rdata", 64'(rsp_rdata), 64'(exp_rdata));
         chk("stall_err", 64'(rsp_err), 64'(exp_err));
         chk("stall_timeout", 64'(rsp_timeout), 64'(exp_to));
         chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      @(negedge HCLK);
      rsp_ready = 1'b0;
      chk("post_valid", 64'(rsp_valid), 64'(0));
      chk("post_busy", 64'(busy), 64'(0));
      chk("post_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("post_rdata_kept", 64'(rsp_rdata), 64'(exp_rdata));
      chk("post_paddr_hold", 64'(PADDR), 64'(exp_paddr));
      $display("xfer wr=%0d addr=%08h waits=%0d hold=%0d -> rdata=%08h err=%0d timeout=%0d",
               wr, addr, waits, hold, rsp_rdata, rsp_err, rsp_timeout);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge HCLK);
      chk("reset_psel", 64'(PSEL), 64'(0));
      chk("reset_penable", 64'(PENABLE), 64'(0));
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_paddr", 64'(PADDR), 64'(0));
      chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
      HRESETn = 1'b1;
      @(negedge HCLK);

      xfer(1'b1, 32'h04, 32'h03, 0, 32'h0, 1'b0, 0);
      xfer(1'b0, 32'h20, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);
      xfer(1'b0, 32'h24, 32'h0, 20, 32'h12345678, 1'b0, 1);
      xfer(1'b0, 32'h28, 32'h0, 7, 32'hCAFEF00D, 1'b0, 0);
      xfer(1'b0, 32'h10, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 5);
      xfer(1'b1, 32'h0B, 32'h55, 0, 32'h0, 1'b0, 0);
      xfer(1'b1, 32'h08, 32'h11, 0, 32'h0, 1'b0, 0);
      xfer(1'b1, 32'h0C, 32'h22, 1, 32'h0, 1'b0, 0);

      // reset in the middle of an ACCESS phase
      while (!cmd_ready) @(negedge HCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h14;
      @(negedge HCLK);
      cmd_valid = 1'b0;
      repeat (2) @(negedge HCLK);
      chk("pre_reset_penable", 64'(PENABLE), 64'(1));
      HRESETn = 1'b0;
      #1;
      chk("mid_reset_psel", 64'(PSEL), 64'(0));
      chk("mid_reset_penable", 64'(PENABLE), 64'(0));
      chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_reset_busy", 64'(busy), 64'(0));
      @(negedge HCLK);
      HRESETn = 1'b1;
      xfer(1'b0, 32'h18, 32'h0, 2, 32'h0BADF00D, 1'b0, 0);

      for (int n = 0; n < 25; n++) begin
         xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)),
              $urandom, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
